agex_issue_stage: RTL and testbench



---
 rtl/agex_issue_stage_pkg.sv | 71 +++++++
 rtl/agex_issue_stage_operand_forward.sv | 27 ++
 rtl/agex_issue_stage.sv | 192 +++++++++++++++++++
 tb/tb_agex_issue_stage.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/agex_issue_stage_pkg.sv
// ---------------------------------------------------------------------------
// agex_issue_stage_pkg
// Shared types for the issue stage in front of the ALU:
//   - core datapath widths
//   - instr_opcode: decoded opcode encoding, with OP_NOP as the idle/default value
//   - issue_entry_t: one held instruction, with its source indices kept for refresh
//   - fwd_select(): EX > WB > regfile operand selection, with x0 always reading 0
// ---------------------------------------------------------------------------
package agex_issue_stage_pkg;

    localparam int CORE_XLEN      = 32;
    localparam int CORE_REGADDR_W = 5;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_SLL   = 4'h6,
        OP_SRL   = 4'h7,
        OP_SRA   = 4'h8,
        OP_SLT   = 4'h9,
        OP_ADD_I = 4'hA,
        OP_AND_I = 4'hB,
        OP_OR_I  = 4'hC,
        OP_XOR_I = 4'hD
    } instr_opcode;

    localparam instr_opcode OPCODE_DEFAULT = OP_NOP;

    // rs1/rs2 are kept so a stalled entry can keep picking up
    // EX/WB results that arrive after it was captured.
    typedef struct packed {
        logic                      valid;
        instr_opcode               opcode;
        logic [CORE_REGADDR_W-1:0] rs1;
        logic [CORE_REGADDR_W-1:0] rs2;
        logic                      use_rs2;
        logic [CORE_XLEN-1:0]      val1;
        logic [CORE_XLEN-1:0]      val2;
        logic [CORE_XLEN-1:0]      imm;
        logic [CORE_XLEN-1:0]      pc;
        logic [CORE_REGADDR_W-1:0] rd;
    } issue_entry_t;

    // EX is the younger result, so it overrides WB.
    // x0 is hardwired to zero, even if a producer claims to write it.
    function automatic logic [CORE_XLEN-1:0] fwd_select(
        input logic [CORE_REGADDR_W-1:0] rs,
        input logic [CORE_XLEN-1:0]      regdata,
        input logic                      ex_v,
        input logic [CORE_REGADDR_W-1:0] ex_rd,
        input logic [CORE_XLEN-1:0]      ex_d,
        input logic                      wb_v,
        input logic [CORE_REGADDR_W-1:0] wb_rd,
        input logic [CORE_XLEN-1:0]      wb_d
    );
        if (rs == '0) begin
            return '0;
        end else if (ex_v && (ex_rd == rs)) begin
            return ex_d;
        end else if (wb_v && (wb_rd == rs)) begin
            return wb_d;
        end else begin
            return regdata;
        end
    endfunction

endpackage

// File: rtl/agex_issue_stage_operand_forward.sv
// ---------------------------------------------------------------------------
// operand_forward
// Purely combinational operand selector built on fwd_select().
//   rs, regdata     : source index and its fallback value
//                     (regfile data, or the value already held in an entry)
//   fwd_ex_*        : EX-stage result bypass
//   fwd_wb_*        : WB-stage result bypass
//   val             : selected operand
// ---------------------------------------------------------------------------
module operand_forward
    import agex_issue_stage_pkg::*;
(
    input  logic [CORE_REGADDR_W-1:0] rs,
    input  logic [CORE_XLEN-1:0]      regdata,
    input  logic                      fwd_ex_valid,
    input  logic [CORE_REGADDR_W-1:0] fwd_ex_rd,
    input  logic [CORE_XLEN-1:0]      fwd_ex_data,
    input  logic                      fwd_wb_valid,
    input  logic [CORE_REGADDR_W-1:0] fwd_wb_rd,
    input  logic [CORE_XLEN-1:0]      fwd_wb_data,
    output logic [CORE_XLEN-1:0]      val
);

    assign val = fwd_select(rs, regdata, fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
                            fwd_wb_valid, fwd_wb_rd, fwd_wb_data);

endmodule

// File: rtl/agex_issue_stage.sv
// ---------------------------------------------------------------------------
// agex_issue_stage
// Issue stage between decode/register-read and the ALU.
//
// Input side:
//   - in_valid/in_ready handshake from decode
//   - instruction payload: opcode, rs1/rs2 with regfile data, use_rs2, imm, pc, rd
// Bypass inputs:
//   - fwd_ex_*, fwd_wb_*
// Control:
//   - flush kills every held instruction
//   - rst is a synchronous, active-high reset
// Output side:
//   - out_valid/out_ready handshake to execute
//   - alu_en mirrors out_valid
//   - registered payload: out_opcode, out_val1, out_val2, out_imm, out_pc, out_rd
//
// Buffering and hazards:
//   - A main + skid pair of entries keeps in_ready a registered function of
//     skid occupancy, with no combinational path from out_ready.
//   - Held entries re-run forwarding on every stalled cycle, so a stalled
//     instruction picks up producer results that arrive after its capture.
//
// XLEN and REGADDR_W must equal the package widths (CORE_XLEN and
// CORE_REGADDR_W), because the entries use the package struct.
// ---------------------------------------------------------------------------
module agex_issue_stage
    import agex_issue_stage_pkg::*;
#(
    parameter int XLEN      = CORE_XLEN,
    parameter int REGADDR_W = CORE_REGADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  instr_opcode          in_opcode,
    input  logic [REGADDR_W-1:0] in_rs1,
    input  logic [REGADDR_W-1:0] in_rs2,
    input  logic [XLEN-1:0]      in_rdata1,
    input  logic [XLEN-1:0]      in_rdata2,
    input  logic                 in_use_rs2,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [REGADDR_W-1:0] in_rd,
    input  logic                 fwd_ex_valid,
    input  logic [REGADDR_W-1:0] fwd_ex_rd,
    input  logic [XLEN-1:0]      fwd_ex_data,
    input  logic                 fwd_wb_valid,
    input  logic [REGADDR_W-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]      fwd_wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 alu_en,
    output instr_opcode          out_opcode,
    output logic [XLEN-1:0]      out_val1,
    output logic [XLEN-1:0]      out_val2,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-1:0]      out_pc,
    output logic [REGADDR_W-1:0] out_rd
);

    issue_entry_t    main_q;
    issue_entry_t    skid_q;
    issue_entry_t    in_entry;
    issue_entry_t    main_ref;
    issue_entry_t    skid_ref;

    logic [XLEN-1:0] in_val1;
    logic [XLEN-1:0] in_val2;
    logic [XLEN-1:0] main_val1;
    logic [XLEN-1:0] main_val2;
    logic [XLEN-1:0] skid_val1;
    logic [XLEN-1:0] skid_val2;

    logic            accept;
    logic            consume;
    logic            main_free;

    // Input-path forwarding for capture.
    operand_forward u_fwd_in1 (
        .rs(in_rs1), .regdata(in_rdata1),
        .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .val(in_val1));
    operand_forward u_fwd_in2 (
        .rs(in_rs2), .regdata(in_rdata2),
        .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .val(in_val2));

    // Refresh paths: a held entry's stored value is the fallback, so it only
    // changes when a matching producer shows up.
    operand_forward u_fwd_main1 (
        .rs(main_q.rs1), .regdata(main_q.val1),
        .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .val(main_val1));
    operand_forward u_fwd_main2 (
        .rs(main_q.rs2), .regdata(main_q.val2),
        .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .val(main_val2));
    operand_forward u_fwd_skid1 (
        .rs(skid_q.rs1), .regdata(skid_q.val1),
        .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .val(skid_val1));
    operand_forward u_fwd_skid2 (
        .rs(skid_q.rs2), .regdata(skid_q.val2),
        .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .val(skid_val2));

    // Build the captured entry and the refreshed copies of the held entries.
    // An immediate in val2 is never replaced by a forwarded value.
    always_comb begin
        in_entry         = '0;
        in_entry.valid   = 1'b1;
        in_entry.opcode  = in_opcode;
        in_entry.rs1     = in_rs1;
        in_entry.rs2     = in_rs2;
        in_entry.use_rs2 = in_use_rs2;
        in_entry.val1    = in_val1;
        in_entry.val2    = in_use_rs2 ? in_val2 : in_imm;
        in_entry.imm     = in_imm;
        in_entry.pc      = in_pc;
        in_entry.rd      = in_rd;

        main_ref      = main_q;
        main_ref.val1 = main_val1;
        if (main_q.use_rs2) begin
            main_ref.val2 = main_val2;
        end

        skid_ref      = skid_q;
        skid_ref.val1 = skid_val1;
        if (skid_q.use_rs2) begin
            skid_ref.val2 = skid_val2;
        end
    end

    assign in_ready  = !skid_q.valid && !rst;
    assign accept    = in_valid && in_ready;
    assign consume   = main_q.valid && out_ready;
    assign main_free = !main_q.valid || consume;

    // Entry movement:
    //   - Skid always drains into main before new input is taken, which
    //     keeps instructions in order.
    //   - New input goes into skid only while main is stalled.
    //   - On flush and when main empties, only the valid bits change, so
    //     the output payload holds its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q        <= '0;
            main_q.opcode <= OPCODE_DEFAULT;
            skid_q        <= '0;
            skid_q.opcode <= OPCODE_DEFAULT;
        end else if (flush) begin
            main_q.valid <= 1'b0;
            skid_q.valid <= 1'b0;
        end else if (main_free) begin
            if (skid_q.valid) begin
                main_q       <= skid_ref;
                skid_q.valid <= 1'b0;
            end else if (accept) begin
                main_q <= in_entry;
            end else begin
                main_q.valid <= 1'b0;
            end
        end else begin
            main_q <= main_ref;
            if (skid_q.valid) begin
                skid_q <= skid_ref;
            end else if (accept) begin
                skid_q <= in_entry;
            end
        end
    end

    assign out_valid  = main_q.valid;
    assign alu_en     = main_q.valid;
    assign out_opcode = main_q.opcode;
    assign out_val1   = main_q.val1;
    assign out_val2   = main_q.val2;
    assign out_imm    = main_q.imm;
    assign out_pc     = main_q.pc;
    assign out_rd     = main_q.rd;

endmodule

// File: tb/tb_agex_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_agex_issue_stage
// Self-checking bench for agex_issue_stage.
//   - A table of single-instruction vectors is streamed back to back.
//   - Hand-written sequences cover stall refresh, skid fill/drain, flush and
//     reset in the middle of a stall.
//   - Expected output records go into a queue when an instruction is driven.
//     A negedge monitor pops and compares one record on every output transfer.
// ---------------------------------------------------------------------------
module tb_agex_issue_stage;
    import agex_issue_stage_pkg::*;

    localparam int XW = CORE_XLEN;
    localparam int RW = CORE_REGADDR_W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    instr_opcode   in_opcode;
    logic [RW-1:0] in_rs1;
    logic [RW-1:0] in_rs2;
    logic [XW-1:0] in_rdata1;
    logic [XW-1:0] in_rdata2;
    logic          in_use_rs2;
    logic [XW-1:0] in_imm;
    logic [XW-1:0] in_pc;
    logic [RW-1:0] in_rd;
    logic          fwd_ex_valid;
    logic [RW-1:0] fwd_ex_rd;
    logic [XW-1:0] fwd_ex_data;
    logic          fwd_wb_valid;
    logic [RW-1:0] fwd_wb_rd;
    logic [XW-1:0] fwd_wb_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic          alu_en;
    instr_opcode   out_opcode;
    logic [XW-1:0] out_val1;
    logic [XW-1:0] out_val2;
    logic [XW-1:0] out_imm;
    logic [XW-1:0] out_pc;
    logic [RW-1:0] out_rd;

    // One stimulus record: the instruction, the bypass state while it is
    // presented, and the operands the ALU must finally see.
    typedef struct {
        instr_opcode   op;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic [XW-1:0] rdata1;
        logic [XW-1:0] rdata2;
        logic          use_rs2;
        logic [XW-1:0] imm;
        logic [XW-1:0] pc;
        logic [RW-1:0] rd;
        logic          ex_v;
        logic [RW-1:0] ex_rd;
        logic [XW-1:0] ex_d;
        logic          wb_v;
        logic [RW-1:0] wb_rd;
        logic [XW-1:0] wb_d;
        logic [XW-1:0] exp1;
        logic [XW-1:0] exp2;
    } vec_t;

    typedef struct {
        instr_opcode   op;
        logic [XW-1:0] val1;
        logic [XW-1:0] val2;
        logic [XW-1:0] imm;
        logic [XW-1:0] pc;
        logic [RW-1:0] rd;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[9];
    int   tests_run    = 0;
    int   tests_failed = 0;

    agex_issue_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rdata1(in_rdata1), .in_rdata2(in_rdata2),
        .in_use_rs2(in_use_rs2), .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
        .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_en(alu_en),
        .out_opcode(out_opcode), .out_val1(out_val1), .out_val2(out_val2),
        .out_imm(out_imm), .out_pc(out_pc), .out_rd(out_rd)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keeps a broken design from hanging the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [XW-1:0] actual,
                               input logic [XW-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(instr_opcode op, logic [RW-1:0] rs1, logic [RW-1:0] rs2,
                                   logic [XW-1:0] rdata1, logic [XW-1:0] rdata2,
                                   logic use_rs2, logic [XW-1:0] imm,
                                   logic ex_v, logic [RW-1:0] ex_rd, logic [XW-1:0] ex_d,
                                   logic wb_v, logic [RW-1:0] wb_rd, logic [XW-1:0] wb_d,
                                   logic [XW-1:0] exp1, logic [XW-1:0] exp2);
        vec_t v;
        v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rdata1 = rdata1; v.rdata2 = rdata2;
        v.use_rs2 = use_rs2; v.imm = imm; v.pc = 32'h0; v.rd = 5'd0;
        v.ex_v = ex_v; v.ex_rd = ex_rd; v.ex_d = ex_d;
        v.wb_v = wb_v; v.wb_rd = wb_rd; v.wb_d = wb_d;
        v.exp1 = exp1; v.exp2 = exp2;
        return v;
    endfunction

    // Plain register-sourced instruction with no bypass activity.
    function automatic vec_t mkPlain(logic [RW-1:0] rs1, logic [RW-1:0] rs2,
                                     logic [XW-1:0] d1, logic [XW-1:0] d2,
                                     logic [XW-1:0] pc, logic [RW-1:0] rd);
        vec_t v;
        v = mkVec(OP_ADD, rs1, rs2, d1, d2, 1'b1, 32'h0, 1'b0, 5'd0, 32'h0,
                  1'b0, 5'd0, 32'h0, d1, d2);
        v.pc = pc;
        v.rd = rd;
        return v;
    endfunction

    // Presents one instruction for the coming edge and optionally records
    // the output it must eventually produce.
    task automatic applyStimulus(input vec_t v, input bit expect_out);
        exp_t e;
        in_valid     = 1'b1;
        in_opcode    = v.op;
        in_rs1       = v.rs1;
        in_rs2       = v.rs2;
        in_rdata1    = v.rdata1;
        in_rdata2    = v.rdata2;
        in_use_rs2   = v.use_rs2;
        in_imm       = v.imm;
        in_pc        = v.pc;
        in_rd        = v.rd;
        fwd_ex_valid = v.ex_v;
        fwd_ex_rd    = v.ex_rd;
        fwd_ex_data  = v.ex_d;
        fwd_wb_valid = v.wb_v;
        fwd_wb_rd    = v.wb_rd;
        fwd_wb_data  = v.wb_d;
        if (expect_out) begin
            e.op = v.op; e.val1 = v.exp1; e.val2 = v.exp2;
            e.imm = v.imm; e.pc = v.pc; e.rd = v.rd;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        fwd_ex_valid = 1'b0;
        fwd_wb_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: on the negedge before each output transfer, the
    // presented instruction must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_output: got pc=0x%08h val1=0x%08h, expected no output",
                         out_pc, out_val1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (out_opcode !== e.op || out_val1 !== e.val1 || out_val2 !== e.val2 ||
                    out_imm !== e.imm || out_pc !== e.pc || out_rd !== e.rd) begin
                    tests_failed++;
                    $display("[TB] FAIL output_record: got op=%0d v1=0x%08h v2=0x%08h imm=0x%08h pc=0x%08h rd=%0d, expected op=%0d v1=0x%08h v2=0x%08h imm=0x%08h pc=0x%08h rd=%0d",
                             out_opcode, out_val1, out_val2, out_imm, out_pc, out_rd,
                             e.op, e.val1, e.val2, e.imm, e.pc, e.rd);
                end
            end
        end
    end

    // Main sequence: reset, table stream, then multi-cycle corner cases.
    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_opcode = OP_NOP; in_rs1 = '0; in_rs2 = '0;
        in_rdata1 = '0; in_rdata2 = '0; in_use_rs2 = 1'b0; in_imm = '0;
        in_pc = '0; in_rd = '0;
        fwd_ex_valid = 1'b0; fwd_ex_rd = '0; fwd_ex_data = '0;
        fwd_wb_valid = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;

        vecs[0] = mkVec(OP_ADD_I, 5'd1, 5'd2, 32'd5, 32'd7, 1'b1, 32'd0,
                        1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd5, 32'd7);
        vecs[1] = mkVec(OP_ADD_I, 5'd1, 5'd2, 32'd5, 32'd7, 1'b1, 32'd1,
                        1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd5, 32'd7);
        vecs[2] = mkVec(OP_ADD_I, 5'd1, 5'd2, 32'd5, 32'd7, 1'b1, 32'd2,
                        1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd5, 32'd7);
        vecs[3] = mkVec(OP_ADD, 5'd3, 5'd2, 32'd1, 32'd7, 1'b1, 32'd0,
                        1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'hAA, 32'd7);
        vecs[4] = mkVec(OP_SUB, 5'd3, 5'd2, 32'd1, 32'd7, 1'b1, 32'd0,
                        1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'hBB, 32'd7);
        vecs[5] = mkVec(OP_AND, 5'd0, 5'd2, 32'h55, 32'd7, 1'b1, 32'd0,
                        1'b1, 5'd0, 32'hAA, 1'b0, 5'd0, 32'h0, 32'h0, 32'd7);
        vecs[6] = mkVec(OP_OR_I, 5'd3, 5'd3, 32'd1, 32'd2, 1'b0, 32'hFFFF_FFF0,
                        1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 32'h0, 32'hAA, 32'hFFFF_FFF0);
        vecs[7] = mkVec(OP_XOR, 5'd9, 5'd9, 32'd1, 32'd2, 1'b1, 32'd0,
                        1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 32'h22, 32'h11, 32'h11);
        vecs[8] = mkVec(OP_SLT, 5'd4, 5'd5, 32'd1, 32'd2, 1'b1, 32'd0,
                        1'b1, 5'd5, 32'h33, 1'b1, 5'd4, 32'h44, 32'h44, 32'h33);
        for (int i = 0; i < 9; i++) begin
            vecs[i].pc = 32'h1000 + 32'(4 * i);
            vecs[i].rd = RW'(i + 10);
        end

        // Reset state
        tick();
        tick();
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_alu_en", {31'b0, alu_en}, 32'd0);
        checkOutput("rst_out_val1", out_val1, 32'd0);
        checkOutput("rst_out_val2", out_val2, 32'd0);
        checkOutput("rst_out_opcode", {28'b0, out_opcode}, {28'b0, OP_NOP});
        checkOutput("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready_after", {31'b0, in_ready}, 32'd1);

        // Back-to-back table stream
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], 1'b1);
            checkOutput("flow_in_ready", {31'b0, in_ready}, 32'd1);
            tick();
            checkOutput("flow_alu_en", {31'b0, alu_en}, 32'd1);
        end
        idle();
        tick();
        checkOutput("flow_drained", {31'b0, out_valid}, 32'd0);

        // Stall refresh: a WB result arrives while main is stalled
        out_ready = 1'b0;
        applyStimulus(mkPlain(5'd1, 5'd4, 32'd5, 32'h77, 32'h2000, 5'd20), 1'b0);
        sb_q.push_back('{OP_ADD, 32'd5, 32'h1234, 32'h0, 32'h2000, 5'd20});
        tick();
        idle();
        checkOutput("stall_captured_val2", out_val2, 32'h77);
        tick();
        tick();
        checkOutput("stall_held_val2", out_val2, 32'h77);
        fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd4; fwd_wb_data = 32'h1234;
        tick();
        fwd_wb_valid = 1'b0;
        checkOutput("stall_refreshed_val2", out_val2, 32'h1234);
        checkOutput("stall_still_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        checkOutput("stall_consumed", {31'b0, out_valid}, 32'd0);

        // Skid fill then ordered drain
        out_ready = 1'b0;
        applyStimulus(mkPlain(5'd1, 5'd2, 32'h10, 32'h20, 32'h3000, 5'd21), 1'b1);
        checkOutput("skid_ready_1", {31'b0, in_ready}, 32'd1);
        tick();
        applyStimulus(mkPlain(5'd1, 5'd2, 32'h30, 32'h40, 32'h3004, 5'd22), 1'b1);
        checkOutput("skid_ready_2", {31'b0, in_ready}, 32'd1);
        tick();
        idle();
        checkOutput("skid_full_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("skid_main_pc", out_pc, 32'h3000);
        out_ready = 1'b1;
        tick();
        checkOutput("skid_ready_back", {31'b0, in_ready}, 32'd1);
        checkOutput("skid_second_pc", out_pc, 32'h3004);
        tick();
        checkOutput("skid_drained", {31'b0, out_valid}, 32'd0);

        // Flush with both entries full and input presented
        out_ready = 1'b0;
        applyStimulus(mkPlain(5'd1, 5'd2, 32'h1, 32'h2, 32'h4000, 5'd1), 1'b0);
        tick();
        applyStimulus(mkPlain(5'd1, 5'd2, 32'h3, 32'h4, 32'h4004, 5'd2), 1'b0);
        tick();
        applyStimulus(mkPlain(5'd1, 5'd2, 32'h5, 32'h6, 32'h4008, 5'd3), 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd1);

        // Flush with main full while a transfer is accepted in the flush cycle
        applyStimulus(mkPlain(5'd1, 5'd2, 32'h7, 32'h8, 32'h400C, 5'd4), 1'b0);
        tick();
        applyStimulus(mkPlain(5'd1, 5'd2, 32'h9, 32'hA, 32'h4010, 5'd5), 1'b0);
        checkOutput("flush2_in_ready", {31'b0, in_ready}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        checkOutput("flush2_out_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("flush_no_replay", {31'b0, out_valid}, 32'd0);
        end

        // Reset in the middle of a stall
        out_ready = 1'b0;
        applyStimulus(mkPlain(5'd1, 5'd2, 32'h11, 32'h12, 32'h5000, 5'd6), 1'b0);
        tick();
        applyStimulus(mkPlain(5'd1, 5'd2, 32'h13, 32'h14, 32'h5004, 5'd7), 1'b0);
        tick();
        idle();
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_in_ready_during", {31'b0, in_ready}, 32'd0);
        tick();
        checkOutput("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mid_rst_alu_en", {31'b0, alu_en}, 32'd0);
        checkOutput("mid_rst_out_val1", out_val1, 32'd0);
        checkOutput("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready_after", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mid_rst_no_replay", {31'b0, out_valid}, 32'd0);
        end

        checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
